// File: rtl/prol16_mem_slave_pkg.sv
// -----------------------------------------------------------------------------
// prol16_mem_slave_pkg
//
// Shared types and constants for the PROL16 memory slave:
//   gDataWidth   - CPU bus data and address width
//   word_t       - one bus word
//   mem_state_t  - slave operating mode (LOAD, RUN, HALTED)
//   bus_cycle_t  - decoded meaning of the active-low strobes in one cycle
//   decode_bus   - strobe decoder
//   addr_in_range - true when an address falls inside a memory of given depth
// -----------------------------------------------------------------------------
package prol16_mem_slave_pkg;

   localparam int gDataWidth = 16;

   typedef logic [gDataWidth-1:0] word_t;

   typedef enum logic [1:0] {
      LOAD   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } mem_state_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RD       = 2'd1,
      WR       = 2'd2,
      CONFLICT = 2'd3
   } bus_cycle_t;

   // Strobes are active low. A deselected chip, or a selected chip with
   // neither oe nor we asserted, is an idle cycle. Both asserted together
   // is an illegal bus cycle and is reported rather than served.
   function automatic bus_cycle_t decode_bus(input logic ce_n,
                                             input logic oe_n,
                                             input logic we_n);
      bus_cycle_t cyc;
      cyc = IDLE;
      if (!ce_n) begin
         if (!oe_n && !we_n) begin
            cyc = CONFLICT;
         end else if (!oe_n) begin
            cyc = RD;
         end else if (!we_n) begin
            cyc = WR;
         end
      end
      return cyc;
   endfunction

   // One extra bit on the left so that a depth of 2**gDataWidth still fits.
   function automatic logic addr_in_range(input word_t addr, input int depth);
      logic [gDataWidth:0] depth_w;
      depth_w = depth[gDataWidth:0];
      return ({1'b0, addr} < depth_w);
   endfunction

endpackage

// File: rtl/prol16_mem_slave_if.sv
// -----------------------------------------------------------------------------
// prol16_mem_slave_if
//
// PROL16 CPU memory bus as seen between the CPU and the memory slave.
// Signal names keep the CPU's point of view (_o = driven by the CPU).
//   mem_addr_o     CPU address
//   mem_data_o     CPU write data
//   mem_ce_no      chip enable, active low
//   mem_oe_no      output enable, active low
//   mem_we_no      write enable, active low
//   illegal_inst_o CPU illegal-instruction flag
//   cpu_halt_o     CPU halt flag
//   mem_data_i     read data returned to the CPU
//   cpu_rst_o      reset held on the CPU by the slave, active high
// Modports: master (CPU side), slave (memory side).
// -----------------------------------------------------------------------------
interface prol16_mem_slave_if;
   import prol16_mem_slave_pkg::*;

   word_t mem_addr_o;
   word_t mem_data_o;
   logic  mem_ce_no;
   logic  mem_oe_no;
   logic  mem_we_no;
   logic  illegal_inst_o;
   logic  cpu_halt_o;
   word_t mem_data_i;
   logic  cpu_rst_o;

   modport master (
      output mem_addr_o,
      output mem_data_o,
      output mem_ce_no,
      output mem_oe_no,
      output mem_we_no,
      output illegal_inst_o,
      output cpu_halt_o,
      input  mem_data_i,
      input  cpu_rst_o
   );

   modport slave (
      input  mem_addr_o,
      input  mem_data_o,
      input  mem_ce_no,
      input  mem_oe_no,
      input  mem_we_no,
      input  illegal_inst_o,
      input  cpu_halt_o,
      output mem_data_i,
      output cpu_rst_o
   );

endinterface

// File: rtl/prol16_sat_counter.sv
// -----------------------------------------------------------------------------
// prol16_sat_counter
//
// Up-counter that sticks at all-ones instead of wrapping.
//   clk   clock
//   clr   synchronous clear, has priority over en
//   en    count enable
//   cnt_o current count
// -----------------------------------------------------------------------------
module prol16_sat_counter #(
   parameter int gWidth = 32
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              en,
   output logic [gWidth-1:0] cnt_o
);

   localparam logic [gWidth-1:0] cOne = {{(gWidth-1){1'b0}}, 1'b1};

   logic [gWidth-1:0] cnt_reg;
   logic [gWidth-1:0] cnt_next;

   always_comb begin
      cnt_next = cnt_reg;
      if (en && (cnt_reg != '1)) begin
         cnt_next = cnt_reg + cOne;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

   assign cnt_o = cnt_reg;

endmodule

// File: rtl/prol16_mem_slave.sv
// -----------------------------------------------------------------------------
// prol16_mem_slave
//
// Single-port word memory sitting directly on the PROL16 CPU bus. While in
// LOAD the CPU is held in reset and the memory is filled through the preload
// port; start releases the CPU (RUN). A halt or illegal-instruction flag from
// the CPU ends the run (HALTED) and freezes the statistics until rst.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   bus              CPU memory bus (slave modport)
//   load_valid_i     preload word valid
//   load_addr_i      preload address
//   load_data_i      preload data
//   load_ready_o     preload accepted (high in LOAD)
//   start_i          leave LOAD and release the CPU
//   dbg_addr_i       debug read address
//   dbg_data_o       debug read data, one cycle after dbg_addr_i
//   done_o           run terminated
//   illegal_o        run ended by an illegal instruction
//   bus_err_o        sticky: oe and we asserted together with ce
//   range_err_o      sticky: CPU or preload access beyond gMemDepth
//   cycle_cnt_o      RUN cycles, saturating
//   rd_cnt_o         CPU read cycles, saturating
//   wr_cnt_o         CPU write cycles, saturating
//
// gMemDepth must not exceed 2**gDataWidth.
// -----------------------------------------------------------------------------
module prol16_mem_slave
   import prol16_mem_slave_pkg::*;
#(
   parameter int gMemDepth = 4096,
   parameter int gCntWidth = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   prol16_mem_slave_if.slave    bus,
   input  logic                 load_valid_i,
   input  word_t                load_addr_i,
   input  word_t                load_data_i,
   output logic                 load_ready_o,
   input  logic                 start_i,
   input  word_t                dbg_addr_i,
   output word_t                dbg_data_o,
   output logic                 done_o,
   output logic                 illegal_o,
   output logic                 bus_err_o,
   output logic                 range_err_o,
   output logic [gCntWidth-1:0] cycle_cnt_o,
   output logic [gCntWidth-1:0] rd_cnt_o,
   output logic [gCntWidth-1:0] wr_cnt_o
);

   localparam int cAddrWidth = (gMemDepth > 1) ? $clog2(gMemDepth) : 1;
   localparam int cNumCnt    = 3;
   localparam int cCntCycle  = 0;
   localparam int cCntRd     = 1;
   localparam int cCntWr     = 2;

   // Memory contents deliberately survive rst so a preloaded program and
   // the results of a run can be inspected after the CPU is reset.
   word_t mem [gMemDepth];

   mem_state_t state_reg;
   mem_state_t state_next;
   bus_cycle_t bus_cycle;

   logic cpu_in_range;
   logic load_in_range;
   logic dbg_in_range;

   logic [cAddrWidth-1:0] cpu_idx;
   logic [cAddrWidth-1:0] dbg_idx;

   logic                  mem_we;
   logic [cAddrWidth-1:0] mem_waddr;
   word_t                 mem_wdata;
   logic                  rd_en;
   logic                  cpu_rst;

   word_t mem_data_reg;
   word_t dbg_data_reg;
   logic  bus_err_reg;
   logic  bus_err_next;
   logic  range_err_reg;
   logic  range_err_next;
   logic  illegal_reg;
   logic  illegal_next;

   logic [cNumCnt-1:0]   cnt_en;
   logic [gCntWidth-1:0] cnt_val [cNumCnt];

   // -------------------------------------------------------------------------
   // Address decode
   // -------------------------------------------------------------------------
   assign bus_cycle     = decode_bus(bus.mem_ce_no, bus.mem_oe_no, bus.mem_we_no);
   assign cpu_in_range  = addr_in_range(bus.mem_addr_o, gMemDepth);
   assign load_in_range = addr_in_range(load_addr_i, gMemDepth);
   assign dbg_in_range  = addr_in_range(dbg_addr_i, gMemDepth);
   assign cpu_idx       = bus.mem_addr_o[cAddrWidth-1:0];
   assign dbg_idx       = dbg_addr_i[cAddrWidth-1:0];

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= LOAD;
      end else begin
         state_reg <= state_next;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: next state, memory write port, counter enables, flag updates
   // -------------------------------------------------------------------------
   always_comb begin
      state_next     = state_reg;
      mem_we         = 1'b0;
      mem_waddr      = load_addr_i[cAddrWidth-1:0];
      mem_wdata      = load_data_i;
      rd_en          = 1'b0;
      cnt_en         = '0;
      bus_err_next   = bus_err_reg;
      range_err_next = range_err_reg;
      illegal_next   = illegal_reg;
      cpu_rst        = 1'b0;
      load_ready_o   = 1'b0;
      done_o         = 1'b0;

      case (state_reg)
         LOAD: begin
            cpu_rst      = 1'b1;
            load_ready_o = 1'b1;
            if (load_valid_i) begin
               if (load_in_range) begin
                  mem_we = 1'b1;
               end else begin
                  range_err_next = 1'b1;
               end
            end
            // A load in the same cycle as start still lands: the write
            // port is driven by the loader for this whole cycle.
            if (start_i) begin
               state_next = RUN;
            end
         end

         RUN: begin
            cnt_en[cCntCycle] = 1'b1;
            mem_waddr         = cpu_idx;
            mem_wdata         = bus.mem_data_o;
            // Read and write cycles are counted as bus cycles, whether or
            // not the address hits the memory.
            unique case (bus_cycle)
               RD: begin
                  rd_en          = 1'b1;
                  cnt_en[cCntRd] = 1'b1;
                  if (!cpu_in_range) begin
                     range_err_next = 1'b1;
                  end
               end
               WR: begin
                  cnt_en[cCntWr] = 1'b1;
                  if (cpu_in_range) begin
                     mem_we = 1'b1;
                  end else begin
                     range_err_next = 1'b1;
                  end
               end
               CONFLICT: begin
                  bus_err_next = 1'b1;
               end
               default: begin
               end
            endcase
            // The access of the terminating cycle is still served above.
            if (bus.cpu_halt_o || bus.illegal_inst_o) begin
               state_next   = HALTED;
               illegal_next = bus.illegal_inst_o;
            end
         end

         HALTED: begin
            done_o = 1'b1;
         end

         default: begin
            state_next = LOAD;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Memory array: one write port, two registered read ports
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (mem_we && !rst) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   // CPU read data only changes on a read cycle, otherwise it holds.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_data_reg <= '0;
         dbg_data_reg <= '0;
      end else begin
         if (rd_en) begin
            mem_data_reg <= cpu_in_range ? mem[cpu_idx] : '0;
         end
         dbg_data_reg <= dbg_in_range ? mem[dbg_idx] : '0;
      end
   end

   // -------------------------------------------------------------------------
   // Sticky status flags
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         bus_err_reg   <= 1'b0;
         range_err_reg <= 1'b0;
         illegal_reg   <= 1'b0;
      end else begin
         bus_err_reg   <= bus_err_next;
         range_err_reg <= range_err_next;
         illegal_reg   <= illegal_next;
      end
   end

   // -------------------------------------------------------------------------
   // Statistics counters
   // -------------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < cNumCnt; gi++) begin : g_cnt
         prol16_sat_counter #(
            .gWidth (gCntWidth)
         ) u_cnt (
            .clk   (clk),
            .clr   (rst),
            .en    (cnt_en[gi]),
            .cnt_o (cnt_val[gi])
         );
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign bus.mem_data_i = mem_data_reg;
   assign bus.cpu_rst_o  = cpu_rst;
   assign dbg_data_o     = dbg_data_reg;
   assign bus_err_o      = bus_err_reg;
   assign range_err_o    = range_err_reg;
   assign illegal_o      = illegal_reg;
   assign cycle_cnt_o    = cnt_val[cCntCycle];
   assign rd_cnt_o       = cnt_val[cCntRd];
   assign wr_cnt_o       = cnt_val[cCntWr];

endmodule

// File: tb/tb_prol16_mem_slave.sv
// -----------------------------------------------------------------------------
// tb_prol16_mem_slave
//
// Clears the whole memory through the preload port, runs a table of directed
// vectors, two hand-written multi-cycle sequences (reset mid-run, illegal
// instruction termination) and then randomized segments. A cycle-level
// reference model of the slave is updated every clock and compared with all
// DUT outputs once the memory has been cleared.
// -----------------------------------------------------------------------------
module tb_prol16_mem_slave;

   localparam int       DEPTH   = 4096;
   localparam longint   CNT_MAX = 64'h0000_0000_FFFF_FFFF;
   localparam bit [2:0] OP_IDLE = 3'b111;   // {ce_n, oe_n, we_n}
   localparam bit [2:0] OP_RD   = 3'b001;
   localparam bit [2:0] OP_WR   = 3'b010;
   localparam bit [2:0] OP_CF   = 3'b000;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_valid;
   logic [15:0] load_addr;
   logic [15:0] load_data;
   logic        load_ready;
   logic        start;
   logic [15:0] dbg_addr;
   logic [15:0] dbg_data;
   logic        done;
   logic        illegal;
   logic        bus_err;
   logic        range_err;
   logic [31:0] cycle_cnt;
   logic [31:0] rd_cnt;
   logic [31:0] wr_cnt;

   int checks = 0;
   int errors = 0;
   bit model_chk_en = 1'b0;

   always #5 clk = ~clk;

   prol16_mem_slave_if bus_if ();

   prol16_mem_slave #(
      .gMemDepth (DEPTH),
      .gCntWidth (32)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus_if),
      .load_valid_i (load_valid),
      .load_addr_i  (load_addr),
      .load_data_i  (load_data),
      .load_ready_o (load_ready),
      .start_i      (start),
      .dbg_addr_i   (dbg_addr),
      .dbg_data_o   (dbg_data),
      .done_o       (done),
      .illegal_o    (illegal),
      .bus_err_o    (bus_err),
      .range_err_o  (range_err),
      .cycle_cnt_o  (cycle_cnt),
      .rd_cnt_o     (rd_cnt),
      .wr_cnt_o     (wr_cnt)
   );

   // ---------------------------------------------------------------- model
   typedef enum {M_LOAD, M_RUN, M_HALT} mmode_t;

   mmode_t      m_mode = M_LOAD;
   logic [15:0] m_mem [DEPTH];
   logic [15:0] m_rdata = 16'h0;
   logic [15:0] m_dbg = 16'h0;
   bit          m_bus_err = 1'b0;
   bit          m_range_err = 1'b0;
   bit          m_illegal = 1'b0;
   longint      m_cyc = 0;
   longint      m_rd = 0;
   longint      m_wr = 0;

   function automatic bit in_rng(input logic [15:0] a);
      return int'(a) < DEPTH;
   endfunction

   // Applies the slave's rules to the inputs present at this clock edge.
   task automatic model_step();
      logic [15:0] a;
      if (rst) begin
         m_mode = M_LOAD; m_rdata = 16'h0; m_dbg = 16'h0;
         m_bus_err = 1'b0; m_range_err = 1'b0; m_illegal = 1'b0;
         m_cyc = 0; m_rd = 0; m_wr = 0;
      end else begin
         // debug port sees memory as it was before this edge's write
         m_dbg = in_rng(dbg_addr) ? m_mem[dbg_addr[11:0]] : 16'h0;
         case (m_mode)
            M_LOAD: begin
               if (load_valid) begin
                  if (in_rng(load_addr)) m_mem[load_addr[11:0]] = load_data;
                  else m_range_err = 1'b1;
               end
               if (start) m_mode = M_RUN;
            end
            M_RUN: begin
               if (m_cyc < CNT_MAX) m_cyc++;
               a = bus_if.mem_addr_o;
               if (!bus_if.mem_ce_no) begin
                  if (!bus_if.mem_oe_no && !bus_if.mem_we_no) begin
                     m_bus_err = 1'b1;
                  end else if (!bus_if.mem_oe_no) begin
                     if (m_rd < CNT_MAX) m_rd++;
                     if (in_rng(a)) m_rdata = m_mem[a[11:0]];
                     else begin m_rdata = 16'h0; m_range_err = 1'b1; end
                  end else if (!bus_if.mem_we_no) begin
                     if (m_wr < CNT_MAX) m_wr++;
                     if (in_rng(a)) m_mem[a[11:0]] = bus_if.mem_data_o;
                     else m_range_err = 1'b1;
                  end
               end
               if (bus_if.cpu_halt_o || bus_if.illegal_inst_o) begin
                  m_mode = M_HALT;
                  m_illegal = bus_if.illegal_inst_o;
               end
            end
            default: begin
            end
         endcase
      end
   endtask

   // ---------------------------------------------------------------- checks
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      chk("model.mem_data_i",   64'(bus_if.mem_data_i), 64'(m_rdata));
      chk("model.cpu_rst_o",    64'(bus_if.cpu_rst_o),  64'(m_mode == M_LOAD));
      chk("model.load_ready_o", 64'(load_ready),        64'(m_mode == M_LOAD));
      chk("model.done_o",       64'(done),              64'(m_mode == M_HALT));
      chk("model.illegal_o",    64'(illegal),           64'(m_illegal));
      chk("model.bus_err_o",    64'(bus_err),           64'(m_bus_err));
      chk("model.range_err_o",  64'(range_err),         64'(m_range_err));
      chk("model.dbg_data_o",   64'(dbg_data),          64'(m_dbg));
      chk("model.cycle_cnt_o",  64'(cycle_cnt),         64'(m_cyc));
      chk("model.rd_cnt_o",     64'(rd_cnt),            64'(m_rd));
      chk("model.wr_cnt_o",     64'(wr_cnt),            64'(m_wr));
   endtask

   // One clock: inputs are already driven; outputs are sampled 1 unit later.
   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      if (model_chk_en) check_model();
   endtask

   task automatic set_op(input bit [2:0] op, input logic [15:0] a, input logic [15:0] d);
      bus_if.mem_ce_no  = op[2];
      bus_if.mem_oe_no  = op[1];
      bus_if.mem_we_no  = op[0];
      bus_if.mem_addr_o = a;
      bus_if.mem_data_o = d;
   endtask

   function automatic logic [15:0] rand_addr();
      int r;
      r = int'($urandom_range(0, 15));
      if (r == 0) return 16'h1000;
      if (r == 1) return 16'hFFFF;
      if (r == 2) return 16'h0FFF;
      return 16'($urandom_range(0, 31));
   endfunction

   // ---------------------------------------------------------------- table
   typedef struct {
      string       name;
      bit          rst;
      bit          ld_v;
      bit [15:0]   ld_a;
      bit [15:0]   ld_d;
      bit          start;
      bit [2:0]    op;
      bit [15:0]   addr;
      bit [15:0]   wdata;
      bit [15:0]   dbg_a;
      bit [15:0]   e_rdata;
      bit          e_cpu_rst;
      bit          e_bus_err;
      bit          e_range_err;
      int          e_rd;
      int          e_wr;
      bit [15:0]   e_dbg;
   } vec_t;

   localparam int NVEC = 14;
   vec_t vecs [NVEC];

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish within the time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int nl;
      int nr;
      int pick;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 16'h0;

      rst = 1'b1; load_valid = 1'b0; load_addr = 16'h0; load_data = 16'h0;
      start = 1'b0; dbg_addr = 16'h0;
      set_op(OP_IDLE, 16'h0, 16'h0);
      bus_if.cpu_halt_o = 1'b0; bus_if.illegal_inst_o = 1'b0;
      cycle();
      rst = 1'b0;

      // Bring every word to a known value before anything is compared.
      for (int a = 0; a < DEPTH; a++) begin
         load_valid = 1'b1; load_addr = 16'(a); load_data = 16'h0;
         cycle();
      end
      load_valid = 1'b0;
      model_chk_en = 1'b1;
      $display("memory cleared through preload port (%0d words)", DEPTH);

      //            name           rst ldv ld_a     ld_d      st op       addr     wdata     dbg_a     e_rdata   cr be re rd wr e_dbg
      vecs[0]  = '{"reset",        1, 0, 16'h0000, 16'h0000, 0, OP_IDLE, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 0, 0, 16'h0000};
      vecs[1]  = '{"load_0000",    0, 1, 16'h0000, 16'h1234, 0, OP_IDLE, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 0, 0, 16'h0000};
      vecs[2]  = '{"load_0001",    0, 1, 16'h0001, 16'hBEEF, 0, OP_IDLE, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 0, 0, 16'h1234};
      vecs[3]  = '{"start",        0, 0, 16'h0000, 16'h0000, 1, OP_IDLE, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 0, 0, 0, 0, 0, 16'hBEEF};
      vecs[4]  = '{"rd_0001",      0, 0, 16'h0000, 16'h0000, 0, OP_RD,   16'h0001, 16'h0000, 16'h0001, 16'hBEEF, 0, 0, 0, 1, 0, 16'hBEEF};
      vecs[5]  = '{"wr_0010",      0, 0, 16'h0000, 16'h0000, 0, OP_WR,   16'h0010, 16'hA5A5, 16'h0010, 16'hBEEF, 0, 0, 0, 1, 1, 16'h0000};
      vecs[6]  = '{"rd_0010",      0, 0, 16'h0000, 16'h0000, 0, OP_RD,   16'h0010, 16'h0000, 16'h0010, 16'hA5A5, 0, 0, 0, 2, 1, 16'hA5A5};
      vecs[7]  = '{"conflict",     0, 0, 16'h0000, 16'h0000, 0, OP_CF,   16'h0020, 16'h7777, 16'h0020, 16'hA5A5, 0, 1, 0, 2, 1, 16'h0000};
      vecs[8]  = '{"after_cf",     0, 0, 16'h0000, 16'h0000, 0, OP_IDLE, 16'h0020, 16'h0000, 16'h0020, 16'hA5A5, 0, 1, 0, 2, 1, 16'h0000};
      vecs[9]  = '{"rd_1000",      0, 0, 16'h0000, 16'h0000, 0, OP_RD,   16'h1000, 16'h0000, 16'h0000, 16'h0000, 0, 1, 1, 3, 1, 16'h1234};
      vecs[10] = '{"wr_1000",      0, 0, 16'h0000, 16'h0000, 0, OP_WR,   16'h1000, 16'hFFFF, 16'h0000, 16'h0000, 0, 1, 1, 3, 2, 16'h1234};
      vecs[11] = '{"no_alias",     0, 0, 16'h0000, 16'h0000, 0, OP_IDLE, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 1, 1, 3, 2, 16'h1234};
      vecs[12] = '{"dbg_1000",     0, 0, 16'h0000, 16'h0000, 0, OP_IDLE, 16'h0000, 16'h0000, 16'h1000, 16'h0000, 0, 1, 1, 3, 2, 16'h0000};
      vecs[13] = '{"idle_ce_hi",   0, 0, 16'h0000, 16'h0000, 0, 3'b100,  16'h0001, 16'h0000, 16'hFFFF, 16'h0000, 0, 1, 1, 3, 2, 16'h0000};

      for (int i = 0; i < NVEC; i++) begin
         rst = vecs[i].rst; load_valid = vecs[i].ld_v;
         load_addr = vecs[i].ld_a; load_data = vecs[i].ld_d;
         start = vecs[i].start; dbg_addr = vecs[i].dbg_a;
         set_op(vecs[i].op, vecs[i].addr, vecs[i].wdata);
         cycle();
         chk({vecs[i].name, ".mem_data_i"},  64'(bus_if.mem_data_i), 64'(vecs[i].e_rdata));
         chk({vecs[i].name, ".cpu_rst_o"},   64'(bus_if.cpu_rst_o),  64'(vecs[i].e_cpu_rst));
         chk({vecs[i].name, ".bus_err_o"},   64'(bus_err),           64'(vecs[i].e_bus_err));
         chk({vecs[i].name, ".range_err_o"}, 64'(range_err),         64'(vecs[i].e_range_err));
         chk({vecs[i].name, ".rd_cnt_o"},    64'(rd_cnt),            64'(vecs[i].e_rd));
         chk({vecs[i].name, ".wr_cnt_o"},    64'(wr_cnt),            64'(vecs[i].e_wr));
         chk({vecs[i].name, ".dbg_data_o"},  64'(dbg_data),          64'(vecs[i].e_dbg));
         $display("vector %0d %s: rdata=%h dbg=%h rd=%0d wr=%0d", i, vecs[i].name,
                  bus_if.mem_data_i, dbg_data, rd_cnt, wr_cnt);
      end

      // Reset while running: back to LOAD, counters cleared, memory kept.
      rst = 1'b1; set_op(OP_IDLE, 16'h0, 16'h0); dbg_addr = 16'h0010;
      cycle();
      chk("rst_run.cpu_rst_o",    64'(bus_if.cpu_rst_o), 64'd1);
      chk("rst_run.load_ready_o", 64'(load_ready),       64'd1);
      chk("rst_run.cycle_cnt_o",  64'(cycle_cnt),        64'd0);
      chk("rst_run.rd_cnt_o",     64'(rd_cnt),           64'd0);
      chk("rst_run.wr_cnt_o",     64'(wr_cnt),           64'd0);
      chk("rst_run.bus_err_o",    64'(bus_err),          64'd0);
      rst = 1'b0;
      cycle();
      chk("rst_run.dbg_0010",     64'(dbg_data),         64'hA5A5);
      $display("reset mid-run: cpu_rst=%0b dbg[0010]=%h", bus_if.cpu_rst_o, dbg_data);

      // Illegal instruction during the 7th RUN cycle, with a read served.
      start = 1'b1;
      cycle();
      start = 1'b0;
      chk("ill.cpu_rst_fall", 64'(bus_if.cpu_rst_o), 64'd0);
      repeat (6) cycle();
      bus_if.illegal_inst_o = 1'b1; set_op(OP_RD, 16'h0001, 16'h0);
      cycle();
      bus_if.illegal_inst_o = 1'b0;
      chk("ill.done_o",      64'(done),              64'd1);
      chk("ill.illegal_o",   64'(illegal),           64'd1);
      chk("ill.cycle_cnt_o", 64'(cycle_cnt),         64'd7);
      chk("ill.mem_data_i",  64'(bus_if.mem_data_i), 64'hBEEF);
      chk("ill.cpu_rst_o",   64'(bus_if.cpu_rst_o),  64'd0);
      set_op(OP_WR, 16'h0030, 16'h5555);
      cycle();
      set_op(OP_IDLE, 16'h0, 16'h0); dbg_addr = 16'h0030;
      cycle();
      chk("ill.dbg_0030",     64'(dbg_data),  64'h0000);
      chk("ill.cycle_frozen", 64'(cycle_cnt), 64'd7);
      chk("ill.wr_frozen",    64'(wr_cnt),    64'd0);
      $display("illegal termination: done=%0b illegal=%0b cycles=%0d", done, illegal, cycle_cnt);

      // Randomized runs compared against the model every cycle.
      for (int seg = 0; seg < 25; seg++) begin
         rst = 1'b1; start = 1'b0; load_valid = 1'b0;
         set_op(OP_IDLE, 16'h0, 16'h0);
         bus_if.cpu_halt_o = 1'b0; bus_if.illegal_inst_o = 1'b0;
         cycle();
         rst = 1'b0;
         nl = int'($urandom_range(0, 6));
         for (int k = 0; k < nl; k++) begin
            load_valid = 1'b1; load_addr = rand_addr(); load_data = 16'($urandom);
            dbg_addr = rand_addr();
            cycle();
         end
         // start may coincide with a final load
         load_valid = 1'($urandom_range(0, 1)); load_addr = rand_addr();
         load_data = 16'($urandom); start = 1'b1;
         cycle();
         start = 1'b0; load_valid = 1'b0;
         nr = int'($urandom_range(5, 40));
         for (int k = 0; k < nr + 5; k++) begin
            pick = int'($urandom_range(0, 5));
            case (pick)
               0, 1:    set_op(OP_RD, rand_addr(), 16'($urandom));
               2, 3:    set_op(OP_WR, rand_addr(), 16'($urandom));
               4:       set_op(OP_CF, rand_addr(), 16'($urandom));
               default: set_op({1'b1, 2'($urandom)}, rand_addr(), 16'($urandom));
            endcase
            bus_if.cpu_halt_o     = ($urandom_range(0, 29) == 0);
            bus_if.illegal_inst_o = ($urandom_range(0, 29) == 0);
            dbg_addr = rand_addr();
            cycle();
         end
         bus_if.cpu_halt_o = 1'b0; bus_if.illegal_inst_o = 1'b0;
         $display("random segment %0d: %0d loads, %0d bus cycles, done=%0b rd=%0d wr=%0d",
                  seg, nl, nr + 5, done, rd_cnt, wr_cnt);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
